lcd_name_writer: RTL and testbench

//   Downstream consumer of the exercise name ROM. On a start request it walks

---
 rtl/lcd_defs.sv | 30 +++
 rtl/lcd_bus_strobe.sv | 124 ++++++++++++
 rtl/lcd_name_writer.sv | 151 +++++++++++++++
 tb/tb_lcd_name_writer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_defs.sv
// Shared definitions for the LCD name writer.
//   - HD44780 command bytes for the two line start addresses
//   - length of one displayed name and the ASCII padding character
//   - state encodings for the writer FSM and the bus strobe sequencer
package lcd_defs;

  localparam logic [7:0] LCD_CMD_LINE1   = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2   = 8'hC0;
  localparam int         LCD_NAME_LEN    = 16;
  localparam logic [7:0] LCD_ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_SETUP,
    ST_CMD_E,
    ST_CMD_WAIT,
    ST_CHR_SETUP,
    ST_CHR_E,
    ST_CHR_WAIT,
    ST_DONE
  } writer_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_E,
    PH_WAIT
  } strobe_phase_t;

endpackage

// File: rtl/lcd_bus_strobe.sv
// Sequences one LCD bus write: SETUP (1 cycle, data/rs loaded, e low),
// E (E_HIGH_CYCLES cycles, e high), WAIT (SETTLE_CYCLES cycles, e low).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   go            request a transfer; accepted when idle or in the last
//                 settle cycle, so back-to-back transfers have no gap
//   data, rs      byte and register select captured when go is accepted
//   lcd_data/rs/rw/e  registered LCD bus
//   e_last        last cycle of the e-high phase
//   xfer_next     cycle before the last settle cycle (lets the caller issue
//                 the next go exactly in the last settle cycle)
//   xfer_done     last settle cycle of the current transfer
module lcd_bus_strobe
  import lcd_defs::*;
#(
  parameter int E_HIGH_CYCLES = 12,
  parameter int SETTLE_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [7:0] data,
  input  logic       rs,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       e_last,
  output logic       xfer_next,
  output logic       xfer_done
);

  localparam int CNT_MAX = (E_HIGH_CYCLES > SETTLE_CYCLES) ? E_HIGH_CYCLES : SETTLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] E_LAST = CW'(E_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] S_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] S_NEAR = (SETTLE_CYCLES >= 2) ? CW'(SETTLE_CYCLES - 2) : '0;

  strobe_phase_t phase_reg, phase_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [7:0]    data_reg, data_next;
  logic          rs_reg, rs_next;
  logic          e_reg, e_next;

  assign e_last    = (phase_reg == PH_E) && (cnt_reg == E_LAST);
  assign xfer_done = (phase_reg == PH_WAIT) && (cnt_reg == S_LAST);
  // With a single settle cycle the "one before last" cycle is the last e-high cycle.
  assign xfer_next = (SETTLE_CYCLES == 1) ? e_last
                                          : ((phase_reg == PH_WAIT) && (cnt_reg == S_NEAR));

  always_comb begin
    phase_next = phase_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    rs_next    = rs_reg;
    e_next     = e_reg;
    case (phase_reg)
      PH_IDLE: begin
        if (go) begin
          phase_next = PH_SETUP;
          data_next  = data;
          rs_next    = rs;
          cnt_next   = '0;
        end
      end
      PH_SETUP: begin
        phase_next = PH_E;
        e_next     = 1'b1;
        cnt_next   = '0;
      end
      PH_E: begin
        if (e_last) begin
          phase_next = PH_WAIT;
          e_next     = 1'b0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      PH_WAIT: begin
        if (xfer_done) begin
          cnt_next = '0;
          if (go) begin
            phase_next = PH_SETUP;
            data_next  = data;
            rs_next    = rs;
          end else begin
            phase_next = PH_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        phase_next = PH_IDLE;
        e_next     = 1'b0;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg <= PH_IDLE;
      cnt_reg   <= '0;
      data_reg  <= 8'h00;
      rs_reg    <= 1'b0;
      e_reg     <= 1'b0;
    end else begin
      phase_reg <= phase_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      rs_reg    <= rs_next;
      e_reg     <= e_next;
    end
  end

  assign lcd_data = data_reg;
  assign lcd_rs   = rs_reg;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = e_reg;

endmodule

// File: rtl/lcd_name_writer.sv
// Writes the 16-character name of the selected exercise to LCD line 1:
// one set-DDRAM-address command followed by 16 data writes.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle request, only honoured in IDLE
//   exercise_sel    exercise number latched on acceptance
//   busy, done      status; done is a one-cycle pulse at the end
//   exercise_id, char_index  address to the name ROM
//   ascii_char      combinational ROM data
//   lcd_data/rs/rw/e  registered LCD bus
module lcd_name_writer
  import lcd_defs::*;
#(
  parameter int         E_HIGH_CYCLES = 12,
  parameter int         SETTLE_CYCLES = 2000,
  parameter logic [7:0] LINE_ADDR     = LCD_CMD_LINE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] exercise_sel,
  output logic       busy,
  output logic       done,
  output logic [3:0] exercise_id,
  output logic [4:0] char_index,
  input  logic [7:0] ascii_char,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e
);

  localparam logic [4:0] LAST_CHAR = 5'(LCD_NAME_LEN - 1);

  writer_state_t state_reg, state_next;
  logic [3:0]    exercise_id_reg, exercise_id_next;
  logic [4:0]    char_index_reg, char_index_next;

  logic       go;
  logic [7:0] xfer_data;
  logic       xfer_rs;
  logic       e_last;
  logic       xfer_next;
  logic       xfer_done;

  // Between characters the FSM leaves WAIT one cycle early (xfer_next) so the
  // SETUP state, which issues go, coincides with the strobe's last settle
  // cycle. char_index changes on that edge and is stable for the whole SETUP
  // cycle before the ROM byte is captured. After the final character the FSM
  // waits for the full settle time (xfer_done) before signalling done.
  always_comb begin
    state_next       = state_reg;
    exercise_id_next = exercise_id_reg;
    char_index_next  = char_index_reg;
    go               = 1'b0;
    xfer_data        = LINE_ADDR;
    xfer_rs          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        char_index_next = '0;
        if (start) begin
          exercise_id_next = exercise_sel;
          state_next       = ST_CMD_SETUP;
        end
      end
      ST_CMD_SETUP: begin
        go         = 1'b1;
        state_next = ST_CMD_E;
      end
      ST_CMD_E: begin
        if (xfer_next) begin
          state_next = ST_CHR_SETUP;
        end else if (e_last) begin
          state_next = ST_CMD_WAIT;
        end
      end
      ST_CMD_WAIT: begin
        if (xfer_next) begin
          state_next = ST_CHR_SETUP;
        end
      end
      ST_CHR_SETUP: begin
        go         = 1'b1;
        xfer_data  = ascii_char;
        xfer_rs    = 1'b1;
        state_next = ST_CHR_E;
      end
      ST_CHR_E: begin
        if ((char_index_reg != LAST_CHAR) && xfer_next) begin
          char_index_next = char_index_reg + 1'b1;
          state_next      = ST_CHR_SETUP;
        end else if (e_last) begin
          state_next = ST_CHR_WAIT;
        end
      end
      ST_CHR_WAIT: begin
        if (char_index_reg == LAST_CHAR) begin
          if (xfer_done) begin
            state_next = ST_DONE;
          end
        end else if (xfer_next) begin
          char_index_next = char_index_reg + 1'b1;
          state_next      = ST_CHR_SETUP;
        end
      end
      ST_DONE: begin
        char_index_next = '0;
        state_next      = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      exercise_id_reg <= 4'd0;
      char_index_reg  <= 5'd0;
    end else begin
      state_reg       <= state_next;
      exercise_id_reg <= exercise_id_next;
      char_index_reg  <= char_index_next;
    end
  end

  assign busy        = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  assign done        = (state_reg == ST_DONE);
  assign exercise_id = exercise_id_reg;
  assign char_index  = char_index_reg;

  lcd_bus_strobe #(
    .E_HIGH_CYCLES(E_HIGH_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_strobe (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .data      (xfer_data),
    .rs        (xfer_rs),
    .lcd_data  (lcd_data),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .e_last    (e_last),
    .xfer_next (xfer_next),
    .xfer_done (xfer_done)
  );

endmodule

// File: tb/tb_lcd_name_writer.sv
// Directed bench for lcd_name_writer with E_HIGH_CYCLES=2, SETTLE_CYCLES=3 (T=6).
// The bench models the name ROM and logs every lcd_e strobe.
module tb_lcd_name_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] exercise_sel = 4'd0;
  logic       busy;
  logic       done;
  logic [3:0] exercise_id;
  logic [4:0] char_index;
  logic [7:0] ascii_char;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  logic [8:0] byte_log[$];
  int         rise_log[$];
  int         high_log[$];
  int         stab_err = 0;

  lcd_name_writer #(
    .E_HIGH_CYCLES(2),
    .SETTLE_CYCLES(3),
    .LINE_ADDR(8'h80)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .exercise_sel (exercise_sel),
    .busy         (busy),
    .done         (done),
    .exercise_id  (exercise_id),
    .char_index   (char_index),
    .ascii_char   (ascii_char),
    .lcd_data     (lcd_data),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_e        (lcd_e)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Name ROM stand-in: ids 10..15 (and any unnamed id) return spaces.
  function automatic logic [7:0] rom_char(input logic [3:0] id, input logic [4:0] idx);
    string s;
    case (id)
      4'd2:    s = "Push-Ups";
      4'd3:    s = "Lunges";
      4'd5:    s = "Squats";
      4'd9:    s = "Burpees";
      default: s = "";
    endcase
    if (int'(idx) < s.len()) return s[int'(idx)];
    return 8'h20;
  endfunction

  always_comb ascii_char = rom_char(exercise_id, char_index);

  // Bus monitor: logs strobes and flags any data/rs change while lcd_e is
  // high or within 3 cycles after its fall.
  initial begin
    logic       prev_e;
    logic [8:0] prev_bus;
    int         since_fall;
    int         e_run;
    logic       hold;
    prev_e = 1'b0; prev_bus = '0; since_fall = 99; e_run = 0; hold = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b1; prev_e = 1'b0; e_run = 0; since_fall = 99;
      end else begin
        if (!lcd_e && prev_e) since_fall = 0;
        else if (!lcd_e) since_fall++;
        if (!hold && ({lcd_rs, lcd_data} !== prev_bus) && (lcd_e || since_fall < 3))
          stab_err++;
        if (lcd_e && !prev_e) begin
          byte_log.push_back({lcd_rs, lcd_data});
          rise_log.push_back(cyc);
        end
        if (lcd_e) e_run++;
        else if (prev_e) begin
          high_log.push_back(e_run);
          e_run = 0;
        end
        hold = 1'b0;
      end
      prev_e   = lcd_e;
      prev_bus = {lcd_rs, lcd_data};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_logs();
    byte_log.delete();
    rise_log.delete();
    high_log.delete();
    stab_err = 0;
  endtask

  // Presents start for one edge; n is the acceptance edge index.
  task automatic start_run(input logic [3:0] sel, output int n);
    @(negedge clk);
    start = 1'b1;
    exercise_sel = sel;
    @(negedge clk);
    start = 1'b0;
    exercise_sel = ~sel;
    n = cyc;
  endtask

  // Returns at the negedge where done is seen; optional stray start pulse.
  task automatic wait_done(input int pulse_at, output int d);
    d = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (pulse_at > 0 && i == pulse_at) begin
        start = 1'b1;
        exercise_sel = 4'd5;
      end else if (pulse_at > 0 && i == pulse_at + 1) begin
        start = 1'b0;
      end
      if (done) begin
        d = cyc;
        break;
      end
    end
    start = 1'b0;
    check("done_timeout", 32'(d >= 0), 32'd1);
  endtask

  task automatic check_run(input string tag, input int n, input int d,
                           input logic [3:0] sel, input string name);
    logic [7:0] ch;
    logic [8:0] exp_b;
    check({tag, ":latency"}, 32'(d - n), 32'd103);
    check({tag, ":busy_at_done"}, 32'(busy), 32'd0);
    check({tag, ":exercise_id"}, 32'(exercise_id), 32'(sel));
    check({tag, ":char_index_at_done"}, 32'(char_index), 32'd15);
    check({tag, ":xfer_count"}, 32'(byte_log.size()), 32'd17);
    check({tag, ":high_count"}, 32'(high_log.size()), 32'd17);
    if (rise_log.size() > 0) check({tag, ":first_rise"}, 32'(rise_log[0] - n), 32'd2);
    for (int i = 0; i < byte_log.size() && i < 17; i++) begin
      if (i == 0) exp_b = {1'b0, 8'h80};
      else begin
        ch = (i - 1 < name.len()) ? name[i - 1] : 8'h20;
        exp_b = {1'b1, ch};
      end
      check($sformatf("%s:byte%0d", tag, i), 32'(byte_log[i]), 32'(exp_b));
    end
    for (int i = 0; i < high_log.size(); i++)
      check($sformatf("%s:e_high%0d", tag, i), 32'(high_log[i]), 32'd2);
    for (int i = 1; i < rise_log.size(); i++)
      check($sformatf("%s:rise_gap%0d", tag, i), 32'(rise_log[i] - rise_log[i - 1]), 32'd6);
    check({tag, ":bus_stable"}, 32'(stab_err), 32'd0);
    $display("run %s: id=%0d accepted@%0d done@%0d strobes=%0d", tag, sel, n, d, byte_log.size());
  endtask

  initial begin
    int n;
    int d;
    int e_idle;
    logic found;

    // 1. reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:exercise_id", 32'(exercise_id), 32'd0);
    check("rst:char_index", 32'(char_index), 32'd0);
    check("rst:lcd_data", 32'(lcd_data), 32'h00);
    check("rst:lcd_rs", 32'(lcd_rs), 32'd0);
    check("rst:lcd_e", 32'(lcd_e), 32'd0);
    check("rst:lcd_rw", 32'(lcd_rw), 32'd0);
    rst = 1'b0;
    e_idle = 0;
    repeat (5) begin
      @(negedge clk);
      if (lcd_e || busy) e_idle++;
    end
    check("idle:quiet", 32'(e_idle), 32'd0);

    // 2/3/4. id 2 with a stray start mid-run
    clear_logs();
    start_run(4'd2, n);
    check("id2:busy_after_accept", 32'(busy), 32'd1);
    wait_done(40, d);
    check_run("id2", n, d, 4'd2, "Push-Ups");
    @(negedge clk);
    check("id2:done_pulse_width", 32'(done), 32'd0);

    // 5. reset mid-transfer at char_index 7 with lcd_e high
    clear_logs();
    start_run(4'd2, n);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (char_index == 5'd7 && lcd_e) begin
        found = 1'b1;
        break;
      end
    end
    check("rstmid:reached_char7", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid:lcd_e", 32'(lcd_e), 32'd0);
    check("rstmid:busy", 32'(busy), 32'd0);
    check("rstmid:char_index", 32'(char_index), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    clear_logs();
    start_run(4'd9, n);
    wait_done(0, d);
    check_run("id9", n, d, 4'd9, "Burpees");
    @(negedge clk);

    // 6. id 14 (blank), start in done cycle ignored, one cycle later accepted
    clear_logs();
    start_run(4'd14, n);
    wait_done(0, d);
    check_run("id14", n, d, 4'd14, "");
    clear_logs();
    start = 1'b1;
    exercise_sel = 4'd3;
    @(negedge clk);
    check("done_cycle_start:busy", 32'(busy), 32'd0);
    check("done_cycle_start:done", 32'(done), 32'd0);
    @(negedge clk);
    start = 1'b0;
    exercise_sel = 4'd0;
    n = cyc;
    check("late_start:busy", 32'(busy), 32'd1);
    check("late_start:exercise_id", 32'(exercise_id), 32'd3);
    wait_done(0, d);
    check_run("id3", n, d, 4'd3, "Lunges");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
